// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: run/pause/clear stopwatch sequencing a cascade of BCD decade counters from a prescaler, with lap capture and sticky overflow.
module bcd_stopwatch_ctrl #(
  parameter int DIGITS = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                lap,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] lap_count,
  output logic                lap_valid,
  output logic                running,
  output logic                overflow
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state;
  logic [PW-1:0] p;
  logic cnt_en, tick, lap_acc, c, wrap;
  logic [4*DIGITS-1:0] nxt;
  assign cnt_en = state == RUN && !clear && !stop;
  assign tick = cnt_en && p == PW'(TICK_DIV - 1);
  assign lap_acc = lap && !clear && state != IDLE;
  always_comb begin
    c = tick;
    nxt = count;
    for (int i = 0; i < DIGITS; i++) begin
      nxt[4*i +: 4] = c ? (count[4*i +: 4] == 4'd9 ? 4'd0 : count[4*i +: 4] + 4'd1) : count[4*i +: 4];
      c = c && count[4*i +: 4] == 4'd9;
    end
    wrap = c;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p <= '0;
      count <= '0;
      lap_count <= '0;
      lap_valid <= 1'b0;
      running <= 1'b0;
      overflow <= 1'b0;
    end else begin
      lap_valid <= lap_acc;
      if (lap_acc) lap_count <= count;
      if (clear) begin
        state <= IDLE;
        p <= '0;
        count <= '0;
        running <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (stop && state == RUN) begin
          state <= PAUSE;
          running <= 1'b0;
        end else if (start && !stop && state != RUN) begin
          state <= RUN;
          running <= 1'b1;
        end
        if (cnt_en) begin
          p <= tick ? '0 : p + PW'(1);
          count <= nxt;
          if (wrap) overflow <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb_bcd_stopwatch_ctrl: scoreboard bench; stimulus queues expected state per cycle, a monitor pops and compares.
module tb_bcd_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [7:0] count, lap_count;
  logic lap_valid, running, overflow;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] elc = 8'h00;
  typedef struct {int cyc; logic [7:0] cnt; logic [7:0] lc; logic run; logic ovf; logic lv; string nm;} exp_t;
  typedef struct {int cyc; logic [7:0] v;} lap_t;
  exp_t sq[$];
  lap_t lq[$];
  always #5 clk = ~clk;
  bcd_stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .count(count), .lap_count(lap_count), .lap_valid(lap_valid), .running(running), .overflow(overflow)
  );
  task automatic want(input int d, input logic [7:0] c, input logic r, input logic o, input logic l, input string nm);
    sq.push_back('{cyc + d, c, elc, r, o, l, nm});
  endtask
  task automatic want_lap(input logic [7:0] v);
    elc = v;
    lq.push_back('{cyc + 1, v});
  endtask
  initial forever begin
    exp_t e;
    lap_t q;
    @(posedge clk);
    #2;
    cyc++;
    if (!rst && running) begin
      n_chk++;
      if (count[3:0] > 4'd9 || count[7:4] > 4'd9) begin
        n_fail++;
        $display("FAIL digit_range cyc=%0d: count=%h, digits must be 0..9", cyc, count);
      end
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      e = sq.pop_front();
      n_chk++;
      if (e.cyc != cyc || count !== e.cnt || lap_count !== e.lc || running !== e.run || overflow !== e.ovf || lap_valid !== e.lv) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: count=%h lap_count=%h running=%b overflow=%b lap_valid=%b, expected cyc=%0d count=%h lap_count=%h running=%b overflow=%b lap_valid=%b",
                 e.nm, cyc, count, lap_count, running, overflow, lap_valid, e.cyc, e.cnt, e.lc, e.run, e.ovf, e.lv);
      end
    end
    if (lap_valid === 1'b1) begin
      n_chk++;
      if (lq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_lap cyc=%0d: lap_valid=1 lap_count=%h, expected no pulse", cyc, lap_count);
      end else begin
        q = lq.pop_front();
        if (q.cyc != cyc || lap_count !== q.v) begin
          n_fail++;
          $display("FAIL lap_capture cyc=%0d: lap_count=%h, expected cyc=%0d lap_count=%h", cyc, lap_count, q.cyc, q.v);
        end
      end
    end
  end
  initial begin
    @(negedge clk);
    want(1, 8'h00, 0, 0, 0, "reset");
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    want(1, 8'h00, 1, 0, 0, "start");
    @(negedge clk);
    start = 1'b0;
    want(1, 8'h00, 1, 0, 0, "pre_tick_a");
    want(2, 8'h00, 1, 0, 0, "pre_tick_b");
    want(3, 8'h01, 1, 0, 0, "first_tick");
    repeat (3) @(negedge clk);
    want(2, 8'h01, 1, 0, 0, "partial_p2");
    repeat (2) @(negedge clk);
    stop = 1'b1;
    want(1, 8'h01, 0, 0, 0, "stop");
    @(negedge clk);
    stop = 1'b0;
    want(5, 8'h01, 0, 0, 0, "pause_hold");
    repeat (5) @(negedge clk);
    start = 1'b1;
    want(1, 8'h01, 1, 0, 0, "resume");
    @(negedge clk);
    start = 1'b0;
    want(1, 8'h02, 1, 0, 0, "resume_tick");
    @(negedge clk);
    want(117, 8'h41, 1, 0, 0, "reach_41");
    want(119, 8'h41, 1, 0, 0, "hold_41");
    repeat (119) @(negedge clk);
    lap = 1'b1;
    want_lap(8'h41);
    want(1, 8'h42, 1, 0, 1, "lap_at_tick");
    @(negedge clk);
    lap = 1'b0;
    want(1, 8'h42, 1, 0, 0, "lap_pulse_end");
    @(negedge clk);
    stop = 1'b1;
    lap = 1'b1;
    want_lap(8'h42);
    want(1, 8'h42, 0, 0, 1, "stop_lap");
    @(negedge clk);
    stop = 1'b0;
    want(1, 8'h42, 0, 0, 1, "pause_lap");
    want_lap(8'h42);
    @(negedge clk);
    lap = 1'b0;
    start = 1'b1;
    want(1, 8'h42, 1, 0, 0, "restart");
    @(negedge clk);
    stop = 1'b1;
    want(1, 8'h42, 0, 0, 0, "stop_start");
    @(negedge clk);
    stop = 1'b0;
    want(1, 8'h42, 1, 0, 0, "start_again");
    @(negedge clk);
    start = 1'b0;
    clear = 1'b1;
    lap = 1'b1;
    want(1, 8'h00, 0, 0, 0, "clear_lap");
    @(negedge clk);
    clear = 1'b0;
    want(1, 8'h00, 0, 0, 0, "idle_lap");
    @(negedge clk);
    lap = 1'b0;
    start = 1'b1;
    want(1, 8'h00, 1, 0, 0, "start_wrap_run");
    @(negedge clk);
    start = 1'b0;
    want(297, 8'h99, 1, 0, 0, "full_scale");
    want(299, 8'h99, 1, 0, 0, "full_scale_hold");
    want(300, 8'h00, 1, 1, 0, "wrap");
    want(303, 8'h01, 1, 1, 0, "overflow_sticky");
    repeat (303) @(negedge clk);
    clear = 1'b1;
    want(1, 8'h00, 0, 0, 0, "clear_overflow");
    @(negedge clk);
    clear = 1'b0;
    start = 1'b1;
    want(1, 8'h00, 1, 0, 0, "start_57_run");
    @(negedge clk);
    start = 1'b0;
    want(171, 8'h57, 1, 0, 0, "reach_57");
    repeat (171) @(negedge clk);
    lap = 1'b1;
    want_lap(8'h57);
    want(1, 8'h57, 1, 0, 1, "lap_57");
    @(negedge clk);
    lap = 1'b0;
    rst = 1'b1;
    start = 1'b1;
    elc = 8'h00;
    want(1, 8'h00, 0, 0, 0, "rst_mid_run");
    @(negedge clk);
    rst = 1'b0;
    want(1, 8'h00, 1, 0, 0, "post_rst_start");
    @(negedge clk);
    start = 1'b0;
    want(2, 8'h00, 1, 0, 0, "post_rst_pre_tick");
    want(3, 8'h01, 1, 0, 0, "post_rst_tick");
    repeat (5) @(negedge clk);
    n_chk++;
    if (sq.size() != 0 || lq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending state checks=%0d lap checks=%0d, expected 0 and 0", sq.size(), lq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
